// File: rtl/cmatmul_pkg.sv
// Shared definitions for the 2x2 complex matrix multiply controller:
// default widths, FSM state encoding and buffer sizes.
package cmatmul_pkg;

   localparam int DW_DEF     = 8;
   localparam int OW_DEF     = 2 * DW_DEF + 2;
   localparam int N_OPERANDS = 8;
   localparam int N_RESULTS  = 4;

   typedef enum logic [1:0] {
      LOAD    = 2'd0,
      COMPUTE = 2'd1,
      OUTPUT  = 2'd2
   } state_t;

endpackage

// File: rtl/cmplx_mul.sv
// Combinational signed complex multiplier; each result component is one bit
// wider than a raw product so the sum/difference of two products cannot wrap.
module cmplx_mul
   import cmatmul_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic signed [DW-1:0] a_real,
   input  logic signed [DW-1:0] a_imag,
   input  logic signed [DW-1:0] b_real,
   input  logic signed [DW-1:0] b_imag,
   output logic signed [2*DW:0] p_real,
   output logic signed [2*DW:0] p_imag
);

   logic signed [2*DW-1:0] rr_s;
   logic signed [2*DW-1:0] ii_s;
   logic signed [2*DW-1:0] ri_s;
   logic signed [2*DW-1:0] ir_s;

   assign rr_s = a_real * b_real;
   assign ii_s = a_imag * b_imag;
   assign ri_s = a_real * b_imag;
   assign ir_s = a_imag * b_real;

   assign p_real = {rr_s[2*DW-1], rr_s} - {ii_s[2*DW-1], ii_s};
   assign p_imag = {ri_s[2*DW-1], ri_s} + {ir_s[2*DW-1], ir_s};

endmodule

// File: rtl/complex_matmul_ctrl.sv
// 2x2 complex matrix multiply C = A x B: streams in 8 operands, runs 8
// multiply/accumulate steps on one shared multiplier, streams out 4 results.
module complex_matmul_ctrl
   import cmatmul_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int OW = 2 * DW + 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [DW-1:0] in_real,
   input  logic signed [DW-1:0] in_imag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [OW-1:0] out_real,
   output logic signed [OW-1:0] out_imag,
   output logic                 busy
);

   localparam int PW = 2 * DW + 1;

   state_t               state_r;
   logic [2:0]           load_cnt_r;
   logic [2:0]           step_r;
   logic [1:0]           out_cnt_r;
   logic signed [DW-1:0] op_re_r [N_OPERANDS];
   logic signed [DW-1:0] op_im_r [N_OPERANDS];
   logic signed [OW-1:0] c_re_r  [N_RESULTS];
   logic signed [OW-1:0] c_im_r  [N_RESULTS];
   logic signed [OW-1:0] acc_re_r;
   logic signed [OW-1:0] acc_im_r;
   logic                 in_ready_r;
   logic                 out_valid_r;
   logic                 busy_r;
   logic signed [OW-1:0] out_real_r;
   logic signed [OW-1:0] out_imag_r;

   logic [2:0]           a_idx_s;
   logic [2:0]           b_idx_s;
   logic [1:0]           elem_s;
   logic [1:0]           out_nxt_s;
   logic signed [PW-1:0] mul_re_s;
   logic signed [PW-1:0] mul_im_s;
   logic signed [OW-1:0] prod_re_s;
   logic signed [OW-1:0] prod_im_s;
   logic signed [OW-1:0] sum_re_s;
   logic signed [OW-1:0] sum_im_s;

   // Step k selects element e=k[2:1] (row k[2], col k[1]) and term t=k[0]:
   // A lives in slots 0..3 as {i,t}, B in slots 4..7 as {t,j}.
   assign elem_s    = step_r[2:1];
   assign a_idx_s   = {1'b0, step_r[2], step_r[0]};
   assign b_idx_s   = {1'b1, step_r[0], step_r[1]};
   assign out_nxt_s = out_cnt_r + 2'd1;

   cmplx_mul #(.DW(DW)) u_mul (
      .a_real (op_re_r[a_idx_s]),
      .a_imag (op_im_r[a_idx_s]),
      .b_real (op_re_r[b_idx_s]),
      .b_imag (op_im_r[b_idx_s]),
      .p_real (mul_re_s),
      .p_imag (mul_im_s)
   );

   assign prod_re_s = {{(OW-PW){mul_re_s[PW-1]}}, mul_re_s};
   assign prod_im_s = {{(OW-PW){mul_im_s[PW-1]}}, mul_im_s};
   assign sum_re_s  = acc_re_r + prod_re_s;
   assign sum_im_s  = acc_im_r + prod_im_s;

   // FSM, buffers, counters and registered handshake/data outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= LOAD;
         load_cnt_r  <= 3'd0;
         step_r      <= 3'd0;
         out_cnt_r   <= 2'd0;
         acc_re_r    <= '0;
         acc_im_r    <= '0;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         out_real_r  <= '0;
         out_imag_r  <= '0;
         for (int n = 0; n < N_OPERANDS; n++) begin
            op_re_r[n] <= '0;
            op_im_r[n] <= '0;
         end
         for (int n = 0; n < N_RESULTS; n++) begin
            c_re_r[n] <= '0;
            c_im_r[n] <= '0;
         end
      end else begin
         case (state_r)
            LOAD: begin
               in_ready_r <= 1'b1;
               if (in_valid && in_ready_r) begin
                  op_re_r[load_cnt_r] <= in_real;
                  op_im_r[load_cnt_r] <= in_imag;
                  if (load_cnt_r == 3'(N_OPERANDS - 1)) begin
                     load_cnt_r <= 3'd0;
                     step_r     <= 3'd0;
                     state_r    <= COMPUTE;
                     in_ready_r <= 1'b0;
                     busy_r     <= 1'b1;
                  end else begin
                     load_cnt_r <= load_cnt_r + 3'd1;
                  end
               end
            end
            COMPUTE: begin
               step_r <= step_r + 3'd1;
               if (!step_r[0]) begin
                  acc_re_r <= prod_re_s;
                  acc_im_r <= prod_im_s;
               end else begin
                  acc_re_r       <= sum_re_s;
                  acc_im_r       <= sum_im_s;
                  c_re_r[elem_s] <= sum_re_s;
                  c_im_r[elem_s] <= sum_im_s;
               end
               if (step_r == 3'd7) begin
                  state_r     <= OUTPUT;
                  out_cnt_r   <= 2'd0;
                  out_valid_r <= 1'b1;
                  out_real_r  <= c_re_r[0];
                  out_imag_r  <= c_im_r[0];
               end
            end
            OUTPUT: begin
               if (out_ready) begin
                  if (out_cnt_r == 2'(N_RESULTS - 1)) begin
                     state_r     <= LOAD;
                     out_cnt_r   <= 2'd0;
                     out_valid_r <= 1'b0;
                     out_real_r  <= '0;
                     out_imag_r  <= '0;
                     busy_r      <= 1'b0;
                     in_ready_r  <= 1'b1;
                  end else begin
                     out_cnt_r  <= out_nxt_s;
                     out_real_r <= c_re_r[out_nxt_s];
                     out_imag_r <= c_im_r[out_nxt_s];
                  end
               end
            end
            default: begin
               state_r     <= LOAD;
               in_ready_r  <= 1'b0;
               out_valid_r <= 1'b0;
               busy_r      <= 1'b0;
               out_real_r  <= '0;
               out_imag_r  <= '0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_real  = out_real_r;
   assign out_imag  = out_imag_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_complex_matmul_ctrl.sv
// Directed self-checking bench for complex_matmul_ctrl with hand-computed
// expected products, latency, backpressure and mid-compute reset cases.
module tb_complex_matmul_ctrl;

   localparam int DW = 8;
   localparam int OW = 2 * DW + 2;

   logic                 clk;
   logic                 rst_n;
   logic                 in_valid;
   logic                 in_ready;
   logic signed [DW-1:0] in_real;
   logic signed [DW-1:0] in_imag;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [OW-1:0] out_real;
   logic signed [OW-1:0] out_imag;
   logic                 busy;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc;
   logic seen_valid;

   logic signed [DW-1:0] ld_re [8];
   logic signed [DW-1:0] ld_im [8];
   int exp_re [4];
   int exp_im [4];

   complex_matmul_ctrl #(.DW(DW), .OW(OW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_real   (in_real),
      .in_imag   (in_imag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_real  (out_real),
      .out_imag  (out_imag),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Gap cycles drive junk data with in_valid low; it must be ignored.
   task automatic load_ops(input bit gaps);
      for (int n = 0; n < 8; n++) begin
         in_valid = 1'b1;
         in_real  = ld_re[n];
         in_imag  = ld_im[n];
         step();
         if (gaps && n < 7) begin
            in_valid = 1'b0;
            in_real  = 8'sd99;
            in_imag  = -8'sd77;
            step();
         end
      end
      in_valid = 1'b0;
      in_real  = 8'sd0;
      in_imag  = 8'sd0;
   endtask

   // Called just after the 8th transfer edge; that edge counts as cycle 1.
   task automatic wait_valid(input string tag, output int cycles);
      cycles = 1;
      while (out_valid !== 1'b1 && cycles < 30) begin
         step();
         cycles++;
      end
      chk({tag, "_first_valid"}, out_valid, 1);
   endtask

   task automatic read_results(input string tag);
      out_ready = 1'b1;
      for (int r = 0; r < 4; r++) begin
         chk($sformatf("%s_valid%0d", tag, r), out_valid, 1);
         chk($sformatf("%s_re%0d", tag, r), out_real, exp_re[r]);
         chk($sformatf("%s_im%0d", tag, r), out_imag, exp_im[r]);
         step();
      end
      chk({tag, "_in_ready_after"}, in_ready, 1);
      chk({tag, "_out_valid_after"}, out_valid, 0);
      chk({tag, "_out_real_after"}, out_real, 0);
      chk({tag, "_busy_after"}, busy, 0);
   endtask

   task automatic set_identity();
      ld_re  = '{8'sd1, 8'sd0, 8'sd0, 8'sd1, 8'sd2, 8'sd4, 8'sd1, 8'sd1};
      ld_im  = '{8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd3, 8'sd5, 8'sd1, 8'sd2};
      exp_re = '{2, 4, 1, 1};
      exp_im = '{3, 5, 1, 2};
   endtask

   // A = [1+1i, 2; 1i, -1], B = [2+3i, 4+5i; 1+1i, 1+2i]
   task automatic set_mixed();
      ld_re  = '{8'sd1, 8'sd2, 8'sd0, -8'sd1, 8'sd2, 8'sd4, 8'sd1, 8'sd1};
      ld_im  = '{8'sd1, 8'sd0, 8'sd1, 8'sd0, 8'sd3, 8'sd5, 8'sd1, 8'sd2};
      exp_re = '{1, 1, -4, -6};
      exp_im = '{7, 13, 1, 2};
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_real   = 8'sd0;
      in_imag   = 8'sd0;
      out_ready = 1'b0;

      #12;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_real", out_real, 0);
      chk("rst_out_imag", out_imag, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      step();
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_busy", busy, 0);

      // Identity A passes B through unchanged
      set_identity();
      load_ops(1'b0);
      wait_valid("ident", cyc);
      read_results("ident");

      // All 1+1i: every entry is 2*(2i) = 4i; check the 9-cycle latency
      ld_re  = '{8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1};
      ld_im  = '{8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1};
      exp_re = '{0, 0, 0, 0};
      exp_im = '{4, 4, 4, 4};
      load_ops(1'b0);
      wait_valid("ones", cyc);
      chk("ones_latency", cyc, 9);
      read_results("ones");

      // Extreme operands: (-128-128i)(-128+127i) = 32640+128i, doubled
      ld_re  = '{8'sh80, 8'sh80, 8'sh80, 8'sh80, 8'sh80, 8'sh80, 8'sh80, 8'sh80};
      ld_im  = '{8'sh80, 8'sh80, 8'sh80, 8'sh80, 8'sd127, 8'sd127, 8'sd127, 8'sd127};
      exp_re = '{65280, 65280, 65280, 65280};
      exp_im = '{256, 256, 256, 256};
      load_ops(1'b0);
      wait_valid("ext", cyc);
      read_results("ext");

      // Backpressure: hold C01 for 5 cycles
      set_mixed();
      load_ops(1'b0);
      wait_valid("stall", cyc);
      out_ready = 1'b1;
      chk("stall_c00_re", out_real, exp_re[0]);
      chk("stall_c00_im", out_imag, exp_im[0]);
      step();
      out_ready = 1'b0;
      for (int s = 0; s < 5; s++) begin
         chk($sformatf("stall_hold_valid%0d", s), out_valid, 1);
         chk($sformatf("stall_hold_re%0d", s), out_real, exp_re[1]);
         chk($sformatf("stall_hold_im%0d", s), out_imag, exp_im[1]);
         step();
      end
      out_ready = 1'b1;
      chk("stall_c01_re", out_real, exp_re[1]);
      chk("stall_c01_im", out_imag, exp_im[1]);
      step();
      chk("stall_c10_re", out_real, exp_re[2]);
      chk("stall_c10_im", out_imag, exp_im[2]);
      step();
      chk("stall_c11_valid", out_valid, 1);
      chk("stall_c11_re", out_real, exp_re[3]);
      chk("stall_c11_im", out_imag, exp_im[3]);
      step();
      chk("stall_in_ready_after", in_ready, 1);
      chk("stall_out_valid_after", out_valid, 0);

      // Same data with in_valid toggling every cycle
      set_mixed();
      load_ops(1'b1);
      wait_valid("gap", cyc);
      read_results("gap");

      // Reset at COMPUTE step k=4 abandons the operation
      set_mixed();
      load_ops(1'b0);
      for (int s = 0; s < 4; s++) step();
      chk("midrst_busy_before", busy, 1);
      chk("midrst_in_ready_before", in_ready, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_in_ready", in_ready, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      step();
      chk("midrst_in_ready_release", in_ready, 1);
      seen_valid = 1'b0;
      for (int s = 0; s < 12; s++) begin
         step();
         seen_valid = seen_valid | out_valid;
      end
      chk("midrst_no_partial", seen_valid, 0);
      set_identity();
      load_ops(1'b0);
      wait_valid("fresh", cyc);
      chk("fresh_latency", cyc, 9);
      read_results("fresh");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
